// File: rtl/vbs_timing_gen_pkg.sv
// Shared definitions for the composite-video timing generator: pixel-source
// modes and the layout of the bus carried through the latency delay line.
package vbs_timing_gen_pkg;

    // Pixel source selection
    localparam logic [1:0] VBS_MODE_EXT    = 2'd0;
    localparam logic [1:0] VBS_MODE_BORDER = 2'd1;
    localparam logic [1:0] VBS_MODE_CHECK  = 2'd2;
    localparam logic [1:0] VBS_MODE_BLANK  = 2'd3;

    // Signals that travel together through the latency pipeline
    typedef struct packed {
        logic sync;
        logic active;
        logic pattern;
    } vbs_tap_t;

    // Idle level of the pipeline: sync high (no sync tip), no video
    localparam vbs_tap_t VBS_TAP_RESET = '{sync: 1'b1, active: 1'b0, pattern: 1'b0};

endpackage

// File: rtl/vbs_delay_line.sv
// Fixed-depth shift register with an asynchronous active-low reset to a
// configurable value. DEPTH=0 degenerates to a plain wire.
module vbs_delay_line #(
    parameter int              WIDTH     = 1,
    parameter int              DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset are not needed when there is nothing to store
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset_n;
            assign dout = din;
        end else begin : g_taps
            logic [WIDTH-1:0] taps_q [DEPTH];

            // Shift din one tap per clock; reset loads every tap with RESET_VAL
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        taps_q[i] <= RESET_VAL;
                    end
                end else begin
                    taps_q[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        taps_q[i] <= taps_q[i-1];
                    end
                end
            end

            assign dout = taps_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vbs_timing_gen.sv
// Composite-video timing and pixel generator: h/v counters, registered
// stage-1 decode (sync, active area, coordinates, line/frame pulses), a
// frame-latched pixel-source mode and a latency-matched output stage.
module vbs_timing_gen
    import vbs_timing_gen_pkg::*;
#(
    parameter int H_TOTAL       = 512,
    parameter int H_SYNC        = 37,
    parameter int H_ACT_START   = 96,
    parameter int H_ACT_W       = 384,
    parameter int V_TOTAL       = 313,
    parameter int V_SYNC_LINES  = 3,
    parameter int V_ACT_START   = 36,
    parameter int V_ACT_H       = 272,
    parameter int PIXEL_LATENCY = 1,
    localparam int XW           = $clog2(H_ACT_W),
    localparam int YW           = $clog2(V_ACT_H)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    mode,
    input  logic          pixel_in,
    output logic          sync,
    output logic          pixel,
    output logic          active,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    logic          sync_raw_d, sync_raw_q;
    logic          active_d, active_q;
    logic [XW-1:0] x_d, x_q;
    logic [YW-1:0] y_d, y_q;
    logic          line_start_d, line_start_q;
    logic          frame_start_d, frame_start_q;

    logic [1:0]    mode_q;
    logic          pattern;
    vbs_tap_t      tap_in, tap_out;

    logic          sync_q, pixel_q;

    // Next-state for the line and frame counters; v steps only on the h wrap
    always_comb begin
        h_d = h_q + HW'(1);
        v_d = v_q;
        if (int'(h_q) == H_TOTAL - 1) begin
            h_d = '0;
            if (int'(v_q) == V_TOTAL - 1) begin
                v_d = '0;
            end else begin
                v_d = v_q + VW'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Stage-1 decode of the counters into sync level, active window and coordinates
    always_comb begin
        logic h_in, v_in, sync_low;
        h_in = (int'(h_q) >= H_ACT_START) && (int'(h_q) < H_ACT_START + H_ACT_W);
        v_in = (int'(v_q) >= V_ACT_START) && (int'(v_q) < V_ACT_START + V_ACT_H);

        if (int'(v_q) < V_SYNC_LINES) begin
            // Broad pulses: two long sync tips per line, each ended by a short high gap
            sync_low = (int'(h_q) < H_TOTAL / 2 - H_SYNC) ||
                       ((int'(h_q) >= H_TOTAL / 2) && (int'(h_q) < H_TOTAL - H_SYNC));
        end else begin
            sync_low = int'(h_q) < H_SYNC;
        end

        sync_raw_d    = !sync_low;
        active_d      = h_in && v_in;
        // Subtract only inside the window so coordinates never show an underflow
        x_d           = active_d ? XW'(int'(h_q) - H_ACT_START) : '0;
        y_d           = active_d ? YW'(int'(v_q) - V_ACT_START) : '0;
        line_start_d  = (h_q == '0);
        frame_start_d = (h_q == '0) && (v_q == '0);
    end

    // Stage-1 registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_raw_q    <= 1'b1;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            sync_raw_q    <= sync_raw_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Mode is taken only at the start of a frame so a change never tears the picture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= VBS_MODE_BLANK;
        end else if (frame_start_q) begin
            mode_q <= mode;
        end
    end

    // Internal test pattern from the stage-1 coordinates
    always_comb begin
        pattern = 1'b0;
        unique case (mode_q)
            VBS_MODE_BORDER: pattern = (x_q == '0) || (x_q == XW'(H_ACT_W - 1)) ||
                                       (y_q == '0) || (y_q == YW'(V_ACT_H - 1));
            VBS_MODE_CHECK:  pattern = x_q[3] ^ y_q[3];
            VBS_MODE_EXT:    pattern = 1'b0;
            VBS_MODE_BLANK:  pattern = 1'b0;
            default:         pattern = 1'b0;
        endcase
    end

    assign tap_in = '{sync: sync_raw_q, active: active_q, pattern: pattern};

    // Match the external frame-buffer read latency
    vbs_delay_line #(
        .WIDTH    ($bits(vbs_tap_t)),
        .DEPTH    (PIXEL_LATENCY),
        .RESET_VAL(VBS_TAP_RESET)
    ) u_delay (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (tap_in),
        .dout   (tap_out)
    );

    // Output stage: sync and the selected pixel source, blanked outside the active area
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 1'b1;
            pixel_q <= 1'b0;
        end else begin
            sync_q  <= tap_out.sync;
            pixel_q <= tap_out.active &
                       ((mode_q == VBS_MODE_EXT) ? pixel_in : tap_out.pattern);
        end
    end

    assign sync        = sync_q;
    assign pixel       = pixel_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vbs_timing_gen.sv
// Bench for vbs_timing_gen: three instances (default timing with latency 1,
// a small raster with latency 1, the small raster with latency 3) checked
// every cycle against a frame-position model, plus literal spot checks.
module tb_vbs_timing_gen;

    localparam int F0 = 512 * 313;
    localparam int F1 = 64 * 40;
    localparam int KMAX = 8338;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] mode0, mode1, mode2;
    logic       pin0, pin1, pin2;

    logic       s0, p0, a0, ls0, fs0;
    logic [8:0] x0;
    logic [8:0] y0;
    logic       s1, p1, a1, ls1, fs1;
    logic [5:0] x1;
    logic [4:0] y1;
    logic       s2, p2, a2, ls2, fs2;
    logic [5:0] x2;
    logic [4:0] y2;

    int passed = 0;
    int total  = 0;
    int cur_k  = 0;

    bit pin1_hist [0:16383];
    bit pin2_hist [0:16383];
    int frame_mode1 [0:7];
    int cnt6, cnt10;

    vbs_timing_gen u_dut0 (
        .clk(clk), .reset_n(reset_n), .mode(mode0), .pixel_in(pin0),
        .sync(s0), .pixel(p0), .active(a0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0)
    );

    vbs_timing_gen #(
        .H_TOTAL(64), .H_SYNC(5), .H_ACT_START(12), .H_ACT_W(40),
        .V_TOTAL(40), .V_SYNC_LINES(3), .V_ACT_START(6), .V_ACT_H(30),
        .PIXEL_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .mode(mode1), .pixel_in(pin1),
        .sync(s1), .pixel(p1), .active(a1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1)
    );

    vbs_timing_gen #(
        .H_TOTAL(64), .H_SYNC(5), .H_ACT_START(12), .H_ACT_W(40),
        .V_TOTAL(40), .V_SYNC_LINES(3), .V_ACT_START(6), .V_ACT_H(30),
        .PIXEL_LATENCY(3)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .mode(mode2), .pixel_in(pin2),
        .sync(s2), .pixel(p2), .active(a2), .x(x2), .y(y2),
        .line_start(ls2), .frame_start(fs2)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cur_k, got, exp);
    endtask

    function automatic void cfg(input int idx, output int ht, output int hs, output int has,
                                output int haw, output int vt, output int vsl,
                                output int vas, output int vah);
        if (idx == 0) begin
            ht = 512; hs = 37; has = 96; haw = 384; vt = 313; vsl = 3; vas = 36; vah = 272;
        end else begin
            ht = 64;  hs = 5;  has = 12; haw = 40;  vt = 40;  vsl = 3; vas = 6;  vah = 30;
        end
    endfunction

    // Raster position p (clocks since the first counted edge) -> stage-1 view
    function automatic void model(input int idx, input int p, output int act, output int xx,
                                  output int yy, output int syn, output int ls, output int fs);
        int ht, hs, has, haw, vt, vsl, vas, vah, pf, h, v;
        cfg(idx, ht, hs, has, haw, vt, vsl, vas, vah);
        if (p < 0) begin
            act = 0; xx = 0; yy = 0; syn = 1; ls = 0; fs = 0;
            return;
        end
        pf = p % (ht * vt);
        h  = pf % ht;
        v  = pf / ht;
        act = (h >= has && h < has + haw && v >= vas && v < vas + vah) ? 1 : 0;
        xx  = act ? h - has : 0;
        yy  = act ? v - vas : 0;
        if (v < vsl) syn = ((h < ht / 2 - hs) || (h >= ht / 2 && h < ht - hs)) ? 0 : 1;
        else         syn = (h < hs) ? 0 : 1;
        ls = (h == 0) ? 1 : 0;
        fs = (h == 0 && v == 0) ? 1 : 0;
    endfunction

    function automatic int pat(input int m, input int xx, input int yy, input int haw,
                               input int vah, input int pin);
        case (m)
            0:       return pin;
            1:       return (xx == 0 || xx == haw - 1 || yy == 0 || yy == vah - 1) ? 1 : 0;
            2:       return ((xx / 8) + (yy / 8)) % 2;
            default: return 0;
        endcase
    endfunction

    task automatic check_all(input int k);
        for (int idx = 0; idx < 3; idx++) begin
            int act, xx, yy, syn, ls, fs, lat, pp, m, pin, ep;
            int gs, gp, ga, gx, gy, gl, gf;
            int ht, hs, has, haw, vt, vsl, vas, vah;
            cfg(idx, ht, hs, has, haw, vt, vsl, vas, vah);
            case (idx)
                0: begin gs = s0; gp = p0; ga = a0; gx = int'(x0); gy = int'(y0); gl = ls0; gf = fs0; end
                1: begin gs = s1; gp = p1; ga = a1; gx = int'(x1); gy = int'(y1); gl = ls1; gf = fs1; end
                default: begin gs = s2; gp = p2; ga = a2; gx = int'(x2); gy = int'(y2); gl = ls2; gf = fs2; end
            endcase
            model(idx, k - 1, act, xx, yy, syn, ls, fs);
            chk($sformatf("active[%0d]", idx), ga, act);
            chk($sformatf("x[%0d]", idx), gx, xx);
            chk($sformatf("y[%0d]", idx), gy, yy);
            chk($sformatf("line_start[%0d]", idx), gl, ls);
            chk($sformatf("frame_start[%0d]", idx), gf, fs);
            lat = (idx == 2) ? 3 : 1;
            pp  = k - lat - 2;
            model(idx, pp, act, xx, yy, syn, ls, fs);
            if (idx == 0)      m = 1;
            else if (idx == 2) m = 0;
            else               m = (pp >= 0) ? frame_mode1[pp / F1] : 3;
            if (k < 1)         pin = 0;
            else if (idx == 1) pin = pin1_hist[k-1];
            else if (idx == 2) pin = pin2_hist[k-1];
            else               pin = 0;
            ep = act ? pat(m, xx, yy, haw, vah, pin) : 0;
            chk($sformatf("sync[%0d]", idx), gs, syn);
            chk($sformatf("pixel[%0d]", idx), gp, ep);
        end
    endtask

    // Hand-computed spot values that pin the model itself
    task automatic literals(input int k);
        case (k)
            1:    begin chk("lit_fs0_first", fs0, 1); chk("lit_ls0_first", ls0, 1);
                        chk("lit_fs1_first", fs1, 1); end
            513:  begin chk("lit_ls0_line1", ls0, 1); chk("lit_fs0_line1", fs0, 0); end
            515:  chk("lit_broad_a_start", s0, 0);
            733:  chk("lit_broad_a_end", s0, 0);
            734:  chk("lit_broad_gap_a", s0, 1);
            770:  chk("lit_broad_gap_a_end", s0, 1);
            771:  chk("lit_broad_b_start", s0, 0);
            989:  chk("lit_broad_b_end", s0, 0);
            990:  chk("lit_broad_gap_b", s0, 1);
            1026: chk("lit_broad_gap_b_end", s0, 1);
            5121: chk("lit_ls0_line10", ls0, 1);
            5122: chk("lit_sync10_pre", s0, 1);
            5123: chk("lit_sync10_first", s0, 0);
            5159: chk("lit_sync10_last", s0, 0);
            5160: chk("lit_sync10_post", s0, 1);
            399:  chk("lit_border_top_x0", p1, 1);
            417:  chk("lit_border_top_mid", p1, 1);
            673:  chk("lit_border_inner", p1, 0);
            655:  chk("lit_border_left", p1, 1);
            694:  chk("lit_border_right", p1, 1);
            2273: chk("lit_border_bottom_after_change", p1, 1);
            2560: begin chk("lit_fs1_pre", fs1, 0); chk("lit_border_line6_count", cnt6, 40);
                        chk("lit_border_line10_count", cnt10, 2); end
            2561: chk("lit_fs1_second", fs1, 1);
            2959: chk("lit_check_x0y0", p1, 0);
            2967: chk("lit_check_x8y0", p1, 1);
            3471: chk("lit_check_x0y8", p1, 1);
            3479: chk("lit_check_x8y8", p1, 0);
            402:  chk("lit_ext_x1", p2, 1);
            403:  chk("lit_ext_x2", p2, 0);
            644:  chk("lit_sync_lat3_pre", s2, 1);
            645:  chk("lit_sync_lat3_first", s2, 0);
            default: ;
        endcase
    endtask

    task automatic stimulus(input int k);
        int act, xx, yy, syn, ls, fs;
        if (k == 1 + 20 * 64)           mode1 = 2'd2;
        if (k == 1 + F1 + 20 * 64)      mode1 = 2'd0;
        if (k == 1 + 2 * F1 + 20 * 64)  mode1 = 2'd3;
        pin1 = 1'($urandom_range(0, 1));
        pin1_hist[k] = pin1;
        model(2, k - 4, act, xx, yy, syn, ls, fs);
        pin2 = (act != 0) ? 1'(xx % 2) : 1'b0;
        pin2_hist[k] = pin2;
        if (k >= 1 && (k - 1) % F1 == 0) frame_mode1[(k - 1) / F1] = int'(mode1);
    endtask

    initial begin
        reset_n = 1'b1;
        mode0 = 2'd1; mode1 = 2'd1; mode2 = 2'd0;
        pin0 = 1'b0; pin1 = 1'b0; pin2 = 1'b0;
        cnt6 = 0; cnt10 = 0;
        for (int i = 0; i < 8; i++) frame_mode1[i] = 3;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cur_k = 0;
        check_all(0);
        stimulus(0);
        reset_n = 1'b1;
        for (int k = 1; k <= KMAX; k++) begin
            @(posedge clk);
            #1;
            cur_k = k;
            if (k - 3 >= 6 * 64 && k - 3 < 7 * 64 && p1 == 1'b1)  cnt6++;
            if (k - 3 >= 10 * 64 && k - 3 < 11 * 64 && p1 == 1'b1) cnt10++;
            check_all(k);
            literals(k);
            if (k < KMAX) stimulus(k);
        end
        // Mid-line reset must clear outputs without a clock edge
        chk("lit_pre_reset_pixel2", p2, 1);
        chk("lit_pre_reset_active2", a2, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_sync0", s0, 1);  chk("rst_sync1", s1, 1);  chk("rst_sync2", s2, 1);
        chk("rst_pixel1", p1, 0); chk("rst_pixel2", p2, 0);
        chk("rst_active2", a2, 0); chk("rst_x2", int'(x2), 0); chk("rst_y2", int'(y2), 0);
        chk("rst_ls0", ls0, 0); chk("rst_fs0", fs0, 0); chk("rst_x0", int'(x0), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
